square_wave_gen: RTL and testbench

Programmable square-wave generator. It is the transmit-side counterpart of the period-measurement front end: it takes a period in clock cycles and drives a square wave with exactly that period. Period updates are glitch-free and take effect only on period boundaries. Used as a loopback stimulus source for the frequency detector and as a clock-derived test tone (1 kHz–100 kHz at 200 MHz).

---
 rtl/square_wave_gen.sv | 181 ++++++++++++++++++
 tb/tb_square_wave_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_gen.sv
// Programmable square-wave generator: period in clk cycles, glitch-free period updates on boundaries.
// Optional duty-cycle control is compiled in with the DUTY_CTRL_EN macro.
module square_wave_gen #(
   parameter int COUNTER_WIDTH = 18,
   parameter int MIN_PERIOD    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     period_load,
   input  logic [COUNTER_WIDTH-1:0] period_in,
`ifdef DUTY_CTRL_EN
   input  logic [COUNTER_WIDTH-1:0] duty_in,
`endif
   output logic                     wave_out,
   output logic                     cycle_start,
   output logic                     active,
   output logic [COUNTER_WIDTH-1:0] period_cur,
   output logic                     cfg_err
);

   localparam logic [COUNTER_WIDTH-1:0] ONE   = COUNTER_WIDTH'(1);
   localparam logic [COUNTER_WIDTH-1:0] MIN_P = COUNTER_WIDTH'(MIN_PERIOD);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STOPPING
   } state_t;

   state_t                   state_q, state_d;
   logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic [COUNTER_WIDTH-1:0] period_cur_q, period_cur_d;
   logic [COUNTER_WIDTH-1:0] pend_period_q, pend_period_d;
   logic                     pend_valid_q, pend_valid_d;
   logic                     wave_q, wave_d;
   logic                     cycle_start_q, cycle_start_d;
   logic                     active_q, active_d;
   logic                     cfg_err_q, cfg_err_d;
   logic                     load_ok;
   logic                     boundary;
   logic [COUNTER_WIDTH-1:0] high_d;
`ifdef DUTY_CTRL_EN
   logic [COUNTER_WIDTH-1:0] duty_cur_q, duty_cur_d;
   logic [COUNTER_WIDTH-1:0] pend_duty_q, pend_duty_d;
`endif

   always_comb begin
`ifdef DUTY_CTRL_EN
      load_ok = period_load && (period_in >= MIN_P) &&
                (duty_in >= ONE) && (duty_in <= period_in - ONE);
`else
      load_ok = period_load && (period_in >= MIN_P);
`endif
      boundary = (state_q != S_IDLE) && (cnt_q == period_cur_q - ONE);

      state_d       = state_q;
      cnt_d         = cnt_q;
      period_cur_d  = period_cur_q;
      pend_period_d = pend_period_q;
      pend_valid_d  = pend_valid_q;
      cfg_err_d     = period_load && !load_ok;
      wave_d        = 1'b0;
      cycle_start_d = 1'b0;
`ifdef DUTY_CTRL_EN
      duty_cur_d  = duty_cur_q;
      pend_duty_d = pend_duty_q;
`endif

      // Pending is consumed before a same-cycle load is stored, so that load waits a full period.
      if (boundary && pend_valid_q) begin
         period_cur_d = pend_period_q;
         pend_valid_d = 1'b0;
`ifdef DUTY_CTRL_EN
         duty_cur_d = pend_duty_q;
`endif
      end

      if (load_ok) begin
         if (state_q == S_IDLE) begin
            period_cur_d = period_in;
`ifdef DUTY_CTRL_EN
            duty_cur_d = duty_in;
`endif
         end else begin
            pend_period_d = period_in;
            pend_valid_d  = 1'b1;
`ifdef DUTY_CTRL_EN
            pend_duty_d = duty_in;
`endif
         end
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (enable && (period_cur_q != '0)) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (boundary) begin
               cnt_d   = '0;
               state_d = enable ? S_RUN : S_IDLE;
            end else begin
               cnt_d   = cnt_q + ONE;
               state_d = enable ? S_RUN : S_STOPPING;
            end
         end
         S_STOPPING: begin
            if (boundary) begin
               cnt_d   = '0;
               state_d = enable ? S_RUN : S_IDLE;
            end else begin
               cnt_d   = cnt_q + ONE;
               state_d = enable ? S_RUN : S_STOPPING;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

`ifdef DUTY_CTRL_EN
      high_d = duty_cur_d;
`else
      high_d = period_cur_d >> 1;
`endif

      // Outputs are computed from next-cycle values so the registered pins line up with cnt_q.
      if (state_d != S_IDLE) begin
         wave_d        = (cnt_d < high_d);
         cycle_start_d = (cnt_d == '0);
      end
      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         period_cur_q  <= '0;
         pend_period_q <= '0;
         pend_valid_q  <= 1'b0;
         wave_q        <= 1'b0;
         cycle_start_q <= 1'b0;
         active_q      <= 1'b0;
         cfg_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         period_cur_q  <= period_cur_d;
         pend_period_q <= pend_period_d;
         pend_valid_q  <= pend_valid_d;
         wave_q        <= wave_d;
         cycle_start_q <= cycle_start_d;
         active_q      <= active_d;
         cfg_err_q     <= cfg_err_d;
      end
   end

`ifdef DUTY_CTRL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_cur_q  <= '0;
         pend_duty_q <= '0;
      end else begin
         duty_cur_q  <= duty_cur_d;
         pend_duty_q <= pend_duty_d;
      end
   end
`endif

   assign wave_out    = wave_q;
   assign cycle_start = cycle_start_q;
   assign active      = active_q;
   assign period_cur  = period_cur_q;
   assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_square_wave_gen.sv
// Self-checking bench for square_wave_gen: table-driven scenarios, directed corner cases,
// and randomized stimulus compared every cycle against a period-level reference model.
module tb_square_wave_gen;

   localparam int W = 18;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable = 1'b0;
   logic         period_load = 1'b0;
   logic [W-1:0] period_in = '0;
`ifdef DUTY_CTRL_EN
   logic [W-1:0] duty_in = '0;
`endif
   logic         wave_out;
   logic         cycle_start;
   logic         active;
   logic [W-1:0] period_cur;
   logic         cfg_err;

   int checks = 0;
   int errors = 0;

   // Reference model: whether a waveform is running, position within the period,
   // current period, pending period (-1 = none), and the last cfg_err.
   int m_on = 0;
   int m_pos = 0;
   int m_p = 0;
   int m_pend = -1;
   int m_err = 0;

   typedef struct {
      int period;
      int exp_err;
      int exp_high;
      int exp_low;
   } vec_t;
   vec_t tbl[7];

   square_wave_gen #(.COUNTER_WIDTH(W), .MIN_PERIOD(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .period_load (period_load),
      .period_in   (period_in),
`ifdef DUTY_CTRL_EN
      .duty_in     (duty_in),
`endif
      .wave_out    (wave_out),
      .cycle_start (cycle_start),
      .active      (active),
      .period_cur  (period_cur),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Only enable at the end of a period decides whether another period follows.
   task automatic model_step();
      int ok;
      int old_p;
      ok    = (period_load && period_in >= 4) ? 1 : 0;
      m_err = (period_load && ok == 0) ? 1 : 0;
      if (m_on != 0) begin
         if (m_pos == m_p - 1) begin
            if (m_pend >= 0) begin
               m_p    = m_pend;
               m_pend = -1;
            end
            m_pos = 0;
            if (!enable) m_on = 0;
         end else begin
            m_pos++;
         end
         if (ok != 0) m_pend = int'(period_in);
      end else begin
         old_p = m_p;
         if (ok != 0) m_p = int'(period_in);
         if (enable && old_p != 0) begin
            m_on  = 1;
            m_pos = 0;
         end
      end
   endtask

   task automatic model_reset();
      m_on = 0; m_pos = 0; m_p = 0; m_pend = -1; m_err = 0;
   endtask

   task automatic tick();
      int exp_wave;
      @(posedge clk);
      model_step();
      #1;
      exp_wave = (m_on != 0 && m_pos < m_p / 2) ? 1 : 0;
      chk("m_active", int'(active), m_on);
      chk("m_wave", int'(wave_out), exp_wave);
      chk("m_cycle_start", int'(cycle_start), (m_on != 0 && m_pos == 0) ? 1 : 0);
      chk("m_period_cur", int'(period_cur), m_p);
      chk("m_cfg_err", int'(cfg_err), m_err);
   endtask

   task automatic do_load(input int p);
      period_in = W'(p);
`ifdef DUTY_CTRL_EN
      duty_in = W'(p) >> 1;
`endif
      period_load = 1'b1;
      tick();
      period_load = 1'b0;
   endtask

   task automatic wait_cs(input int limit, output int n);
      n = 0;
      while (1) begin
         tick();
         n++;
         if (cycle_start) break;
         if (n >= limit) begin
            chk("wait_cs_timeout", n, -1);
            break;
         end
      end
   endtask

   task automatic wait_idle(input int limit);
      int k;
      k = 0;
      while (active && k < limit) begin
         tick();
         k++;
      end
      if (active) chk("wait_idle_timeout", k, -1);
   endtask

   initial begin
      int n;
      int hi;
      int k;

      tbl[0] = '{10, 0, 5, 5};
      tbl[1] = '{7, 0, 3, 4};
      tbl[2] = '{2, 1, 0, 0};
      tbl[3] = '{4, 0, 2, 2};
      tbl[4] = '{3, 1, 0, 0};
      tbl[5] = '{9, 0, 4, 5};
      tbl[6] = '{0, 1, 0, 0};

      // Reset state
      #22;
      chk("rst_wave", int'(wave_out), 0);
      chk("rst_active", int'(active), 0);
      chk("rst_period_cur", int'(period_cur), 0);
      chk("rst_cycle_start", int'(cycle_start), 0);
      chk("rst_cfg_err", int'(cfg_err), 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         do_load(tbl[i].period);
         chk("tbl_cfg_err", int'(cfg_err), tbl[i].exp_err);
         $display("vec %0d period %0d cfg_err %0d", i, tbl[i].period, cfg_err);
         if (tbl[i].exp_err == 0) begin
            chk("tbl_period_cur", int'(period_cur), tbl[i].period);
            enable = 1'b1;
            tick();
            chk("tbl_first_cs", int'(cycle_start), 1);
            chk("tbl_active", int'(active), 1);
            hi = 0;
            for (int c = 0; c < tbl[i].period; c++) begin
               hi += int'(wave_out);
               tick();
            end
            chk("tbl_next_cs", int'(cycle_start), 1);
            chk("tbl_high", hi, tbl[i].exp_high);
            chk("tbl_low", tbl[i].period - hi, tbl[i].exp_low);
            enable = 1'b0;
            wait_idle(300);
         end
      end

      // Mid-run reload: current period completes, new period on next boundary
      do_load(10);
      enable = 1'b1;
      tick();
      tick(); tick(); tick();
      do_load(200);
      wait_cs(20, n);
      chk("swap_spacing", n + 4, 10);
      chk("swap_period_cur", int'(period_cur), 200);
      hi = 0;
      for (int c = 0; c < 200; c++) begin
         hi += int'(wave_out);
         tick();
      end
      chk("p200_cs", int'(cycle_start), 1);
      chk("p200_high", hi, 100);
      $display("reload 10->200 spacing %0d high %0d", n + 4, hi);

      // Back to 10, then a rejected load must not disturb it
      do_load(10);
      wait_cs(250, n);
      chk("back10_spacing", n + 1, 200);
      chk("back10_period_cur", int'(period_cur), 10);
      do_load(2);
      chk("bad_load_err", int'(cfg_err), 1);
      chk("bad_load_period_cur", int'(period_cur), 10);
      wait_cs(20, n);
      chk("bad_load_spacing", n + 1, 10);
      $display("rejected load 2, spacing %0d", n + 1);

      // Stop during the high phase: period completes, then idle
      tick(); tick();
      chk("stop_high_phase", int'(wave_out), 1);
      enable = 1'b0;
      k = 2;
      while (active && k < 30) begin
         tick();
         k++;
      end
      chk("stop_len", k, 10);
      chk("stop_wave", int'(wave_out), 0);
      $display("stop after %0d cycles", k);

      // Re-enable while stopping: no gap
      enable = 1'b1;
      tick();
      chk("restart_cs", int'(cycle_start), 1);
      enable = 1'b0;
      for (int c = 0; c < 8; c++) tick();
      enable = 1'b1;
      wait_cs(20, n);
      chk("reenable_spacing", 8 + n, 10);
      chk("reenable_active", int'(active), 1);
      $display("re-enable at cnt 8, spacing %0d", 8 + n);

      // Async reset mid-high phase
      tick();
      chk("pre_rst_wave", int'(wave_out), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_wave", int'(wave_out), 0);
      chk("async_rst_active", int'(active), 0);
      chk("async_rst_period_cur", int'(period_cur), 0);
      model_reset();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) tick();
      chk("post_rst_idle", int'(active), 0);
      $display("async reset, active %0d period_cur %0d", active, period_cur);

      // Randomized stimulus against the model
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(19) == 0) enable = ~enable;
         if ($urandom_range(11) == 0) do_load(int'($urandom_range(24)));
         else tick();
      end
      $display("random phase done, checks %0d", checks);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
